// File: rtl/serial_comparator_multidigit.sv
// Serial magnitude comparator: consumes DIGIT_W bits of each operand per valid cycle,
// WORD_DIGITS digits per word, with per-word digit order and signedness.
module serial_comparator_multidigit #(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 16,
  parameter int unsigned CNT_W       = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid,
  input  logic               msb_first,
  input  logic               is_signed,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               done,
  output logic [CNT_W-1:0]   digit_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

  cmp_e             state_q, state_d, digit_cmp, prior;
  logic             mode_q, mode_d, sign_q, sign_d;
  logic             first, mode_eff, sign_eff, sign_digit, digit_lt;
  logic [CNT_W-1:0] cur_idx, idx_d;
  logic             done_d;

  // Per-digit compare; a clear with valid restarts the word at this digit.
  always_comb begin
    first      = clear || (digit_idx == '0);
    mode_eff   = first ? msb_first : mode_q;
    sign_eff   = first ? is_signed : sign_q;
    cur_idx    = clear ? '0 : digit_idx;
    sign_digit = mode_eff ? (cur_idx == '0) : (cur_idx == LAST_IDX);
    if (sign_eff && sign_digit) digit_lt = ($signed(a) < $signed(b));
    else                        digit_lt = (a < b);
    if (digit_lt)     digit_cmp = CMP_LT;
    else if (a == b)  digit_cmp = CMP_EQ;
    else              digit_cmp = CMP_GT;
    prior = first ? CMP_EQ : state_q;
  end

  // Next-state: MSB-first keeps the first difference, LSB-first the last one.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    idx_d   = digit_idx;
    done_d  = 1'b0;
    if (valid) begin
      mode_d = mode_eff;
      sign_d = sign_eff;
      if (mode_eff) state_d = (prior == CMP_EQ) ? digit_cmp : prior;
      else          state_d = (digit_cmp != CMP_EQ) ? digit_cmp : prior;
      if (cur_idx == LAST_IDX) begin
        idx_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = cur_idx + CNT_W'(1);
      end
    end else if (clear) begin
      state_d = CMP_EQ;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CMP_EQ;
      mode_q      <= 1'b0;
      sign_q      <= 1'b0;
      digit_idx   <= '0;
      done        <= 1'b0;
      a_less_b    <= 1'b0;
      a_eq_b      <= 1'b1;
      a_greater_b <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      digit_idx   <= idx_d;
      done        <= done_d;
      a_less_b    <= (state_d == CMP_LT);
      a_eq_b      <= (state_d == CMP_EQ);
      a_greater_b <= (state_d == CMP_GT);
    end
  end

endmodule

// File: tb/tb_serial_comparator_multidigit.sv
// Directed and randomised checks of serial_comparator_multidigit in three configurations.
module tb_serial_comparator_multidigit;

  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  // DIGIT_W=4, WORD_DIGITS=4
  logic       c4_clear, c4_valid, c4_msb, c4_sign;
  logic [3:0] c4_a, c4_b;
  logic       c4_lt, c4_eq, c4_gt, c4_done;
  logic [1:0] c4_idx;
  // DIGIT_W=1, WORD_DIGITS=16
  logic       c1_clear, c1_valid, c1_msb, c1_sign;
  logic [0:0] c1_a, c1_b;
  logic       c1_lt, c1_eq, c1_gt, c1_done;
  logic [3:0] c1_idx;
  // DIGIT_W=8, WORD_DIGITS=1
  logic       c8_clear, c8_valid, c8_msb, c8_sign;
  logic [7:0] c8_a, c8_b;
  logic       c8_lt, c8_eq, c8_gt, c8_done;
  logic [0:0] c8_idx;

  serial_comparator_multidigit #(.DIGIT_W(4), .WORD_DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .clear(c4_clear), .valid(c4_valid), .msb_first(c4_msb),
    .is_signed(c4_sign), .a(c4_a), .b(c4_b), .a_less_b(c4_lt), .a_eq_b(c4_eq),
    .a_greater_b(c4_gt), .done(c4_done), .digit_idx(c4_idx));

  serial_comparator_multidigit #(.DIGIT_W(1), .WORD_DIGITS(16)) u1 (
    .clk(clk), .rst(rst), .clear(c1_clear), .valid(c1_valid), .msb_first(c1_msb),
    .is_signed(c1_sign), .a(c1_a), .b(c1_b), .a_less_b(c1_lt), .a_eq_b(c1_eq),
    .a_greater_b(c1_gt), .done(c1_done), .digit_idx(c1_idx));

  serial_comparator_multidigit #(.DIGIT_W(8), .WORD_DIGITS(1)) u8 (
    .clk(clk), .rst(rst), .clear(c8_clear), .valid(c8_valid), .msb_first(c8_msb),
    .is_signed(c8_sign), .a(c8_a), .b(c8_b), .a_less_b(c8_lt), .a_eq_b(c8_eq),
    .a_greater_b(c8_gt), .done(c8_done), .digit_idx(c8_idx));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-word reference: flags encoded {lt,eq,gt}.
  function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                         input logic sg);
    if (sg ? ($signed(x) < $signed(y)) : (x < y)) return F_LT;
    if (x == y) return F_EQ;
    return F_GT;
  endfunction

  task automatic step4(input logic v, input logic clr, input logic ms, input logic sg,
                       input logic [3:0] aa, input logic [3:0] bb);
    @(negedge clk);
    c4_valid = v; c4_clear = clr; c4_msb = ms; c4_sign = sg; c4_a = aa; c4_b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [2:0] fl, input logic [1:0] idx,
                      input logic dn);
    chk({tag, ".flags"}, 32'({c4_lt, c4_eq, c4_gt}), 32'(fl));
    chk({tag, ".idx"}, 32'(c4_idx), 32'(idx));
    chk({tag, ".done"}, 32'(c4_done), 32'(dn));
  endtask

  task automatic step1(input logic v, input logic ms, input logic sg,
                       input logic aa, input logic bb);
    @(negedge clk);
    c1_valid = v; c1_msb = ms; c1_sign = sg; c1_a = aa; c1_b = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wa, wb;
    logic [7:0]  ba, bb8;
    logic        wm, ws;
    int          bit_pos;

    rst = 1'b1;
    c4_clear = 0; c4_valid = 0; c4_msb = 0; c4_sign = 0; c4_a = 0; c4_b = 0;
    c1_clear = 0; c1_valid = 0; c1_msb = 0; c1_sign = 0; c1_a = 0; c1_b = 0;
    c8_clear = 0; c8_valid = 0; c8_msb = 0; c8_sign = 0; c8_a = 0; c8_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk4("reset", F_EQ, 2'd0, 1'b0);
    chk("reset.u1flags", 32'({c1_lt, c1_eq, c1_gt}), 32'(F_EQ));
    @(negedge clk);
    rst = 1'b0;

    // 1: unsigned MSB-first 0x4126 vs 0x4646
    step4(1, 0, 1, 0, 4'h4, 4'h4); chk4("t1.d0", F_EQ, 2'd1, 1'b0);
    step4(1, 0, 1, 0, 4'h1, 4'h6); chk4("t1.d1", F_LT, 2'd2, 1'b0);
    step4(1, 0, 1, 0, 4'h2, 4'h4); chk4("t1.d2", F_LT, 2'd3, 1'b0);
    step4(1, 0, 1, 0, 4'h6, 4'h6); chk4("t1.d3", F_LT, 2'd0, 1'b1);
    step4(0, 0, 0, 0, 4'h0, 4'h0); chk4("t1.hold", F_LT, 2'd0, 1'b0);

    // 2: same operands LSB-first; mode pin toggled on later digits must be ignored
    step4(1, 0, 0, 0, 4'h6, 4'h6); chk4("t2.d0", F_EQ, 2'd1, 1'b0);
    step4(1, 0, 1, 0, 4'h2, 4'h4); chk4("t2.d1", F_LT, 2'd2, 1'b0);
    step4(1, 0, 1, 1, 4'h1, 4'h6); chk4("t2.d2", F_LT, 2'd3, 1'b0);
    step4(1, 0, 1, 1, 4'h4, 4'h4); chk4("t2.d3", F_LT, 2'd0, 1'b1);

    // 3: signed override, MSB-first 0x8000 vs 0x0001
    step4(1, 0, 1, 1, 4'h8, 4'h0); chk4("t3.ms.d0", F_LT, 2'd1, 1'b0);
    step4(1, 0, 1, 1, 4'h0, 4'h0);
    step4(1, 0, 1, 1, 4'h0, 4'h0);
    step4(1, 0, 1, 1, 4'h0, 4'h1); chk4("t3.ms.d3", F_LT, 2'd0, 1'b1);
    step4(1, 0, 1, 0, 4'h8, 4'h0); chk4("t3.mu.d0", F_GT, 2'd1, 1'b0);
    step4(1, 0, 1, 0, 4'h0, 4'h0);
    step4(1, 0, 1, 0, 4'h0, 4'h0);
    step4(1, 0, 1, 0, 4'h0, 4'h1); chk4("t3.mu.d3", F_GT, 2'd0, 1'b1);
    // LSB-first 0x0001 vs 0x8000
    step4(1, 0, 0, 1, 4'h1, 4'h0); chk4("t3.ls.d0", F_GT, 2'd1, 1'b0);
    step4(1, 0, 0, 1, 4'h0, 4'h0); chk4("t3.ls.d1", F_GT, 2'd2, 1'b0);
    step4(1, 0, 0, 1, 4'h0, 4'h0); chk4("t3.ls.d2", F_GT, 2'd3, 1'b0);
    step4(1, 0, 0, 1, 4'h0, 4'h8); chk4("t3.ls.d3", F_GT, 2'd0, 1'b1);
    step4(1, 0, 0, 0, 4'h1, 4'h0); chk4("t3.lu.d0", F_GT, 2'd1, 1'b0);
    step4(1, 0, 0, 0, 4'h0, 4'h0);
    step4(1, 0, 0, 0, 4'h0, 4'h0); chk4("t3.lu.d2", F_GT, 2'd3, 1'b0);
    step4(1, 0, 0, 0, 4'h0, 4'h8); chk4("t3.lu.d3", F_LT, 2'd0, 1'b1);

    // 4: equal words in both modes, then back-to-back LSB-first 0x0000 vs 0x0001
    step4(1, 0, 1, 0, 4'h4, 4'h4); chk4("t4.m.d0", F_EQ, 2'd1, 1'b0);
    step4(1, 0, 1, 0, 4'h7, 4'h7); chk4("t4.m.d1", F_EQ, 2'd2, 1'b0);
    step4(1, 0, 1, 0, 4'h2, 4'h2); chk4("t4.m.d2", F_EQ, 2'd3, 1'b0);
    step4(1, 0, 1, 0, 4'h6, 4'h6); chk4("t4.m.d3", F_EQ, 2'd0, 1'b1);
    step4(1, 0, 0, 1, 4'h6, 4'h6); chk4("t4.l.d0", F_EQ, 2'd1, 1'b0);
    step4(1, 0, 0, 1, 4'h2, 4'h2); chk4("t4.l.d1", F_EQ, 2'd2, 1'b0);
    step4(1, 0, 0, 1, 4'h7, 4'h7); chk4("t4.l.d2", F_EQ, 2'd3, 1'b0);
    step4(1, 0, 0, 1, 4'h4, 4'h4); chk4("t4.l.d3", F_EQ, 2'd0, 1'b1);
    step4(1, 0, 1, 0, 4'h9, 4'h3); step4(1, 0, 1, 0, 4'h0, 4'h0);
    step4(1, 0, 1, 0, 4'h0, 4'h0); step4(1, 0, 1, 0, 4'h0, 4'h0);
    chk4("t4.prev", F_GT, 2'd0, 1'b1);
    step4(1, 0, 0, 0, 4'h0, 4'h1); chk4("t4.b2b.d0", F_LT, 2'd1, 1'b0);
    step4(1, 0, 0, 0, 4'h0, 4'h0);
    step4(1, 0, 0, 0, 4'h0, 4'h0);
    step4(1, 0, 0, 0, 4'h0, 4'h0); chk4("t4.b2b.d3", F_LT, 2'd0, 1'b1);

    // 5: gaps (operands X while idle), clear with valid, clear alone, async reset
    step4(1, 0, 1, 0, 4'h4, 4'h4);
    step4(1, 0, 1, 0, 4'h1, 4'h6); chk4("t5.pre", F_LT, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step4(0, 0, 0, 1, 4'hx, 4'hx); chk4($sformatf("t5.gap%0d", i), F_LT, 2'd2, 1'b0);
    end
    step4(1, 1, 1, 0, 4'h9, 4'h3); chk4("t5.clrv", F_GT, 2'd1, 1'b0);
    step4(1, 0, 1, 0, 4'h0, 4'h5); chk4("t5.clrv.d1", F_GT, 2'd2, 1'b0);
    step4(0, 1, 0, 0, 4'h0, 4'h0); chk4("t5.clr", F_EQ, 2'd0, 1'b0);
    step4(1, 0, 1, 0, 4'h2, 4'h5);
    step4(1, 0, 1, 0, 4'h2, 4'h5); chk4("t5.prerst", F_LT, 2'd2, 1'b0);
    @(negedge clk);
    c4_valid = 0;
    #2 rst = 1'b1;
    #1 chk4("t5.rst", F_EQ, 2'd0, 1'b0);
    #1 rst = 1'b0;

    // 6a: DIGIT_W=1, WORD_DIGITS=16 random words; mode/sign pins random after digit 0
    for (int w = 0; w < 1000; w++) begin
      wa = 16'($urandom); wb = 16'($urandom);
      if (w % 4 == 0) wb = wa;
      wm = 1'($urandom_range(0, 1)); ws = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
        bit_pos = wm ? 15 - k : k;
        if ($urandom_range(0, 15) == 0) step1(0, 1'($urandom), 1'($urandom), 1'bx, 1'bx);
        step1(1, (k == 0) ? wm : 1'($urandom), (k == 0) ? ws : 1'($urandom),
              wa[bit_pos], wb[bit_pos]);
      end
      chk($sformatf("t6a.w%0d.done", w), 32'(c1_done), 32'd1);
      chk($sformatf("t6a.w%0d.flags", w), 32'({c1_lt, c1_eq, c1_gt}),
          32'(ref_cmp(wa, wb, ws)));
    end
    @(negedge clk); c1_valid = 0;

    // 6b: DIGIT_W=8, WORD_DIGITS=1, every valid digit is a whole word
    for (int w = 0; w < 1000; w++) begin
      ba = 8'($urandom); bb8 = 8'($urandom);
      if (w % 5 == 0) bb8 = ba;
      wm = 1'($urandom_range(0, 1)); ws = 1'($urandom_range(0, 1));
      @(negedge clk);
      c8_valid = 1; c8_msb = wm; c8_sign = ws; c8_a = ba; c8_b = bb8;
      @(posedge clk);
      #1;
      chk($sformatf("t6b.w%0d.done", w), 32'({c8_done, c8_idx}), 32'(2'b10));
      chk($sformatf("t6b.w%0d.flags", w), 32'({c8_lt, c8_eq, c8_gt}),
          32'(ref_cmp(ws ? {{8{ba[7]}}, ba} : {8'h00, ba},
                      ws ? {{8{bb8[7]}}, bb8} : {8'h00, bb8}, ws)));
    end
    @(negedge clk); c8_valid = 0;
    @(posedge clk); #1;
    chk("t6b.idle.done", 32'(c8_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_comparator_multidigit.md
Name: serial_comparator_multidigit

Overview:
- Parametrised serial magnitude comparator. Consumes two operands DIGIT_W bits per cycle over WORD_DIGITS digits.
- Digit order (MSB-first or LSB-first) and signedness are selectable per word.
- Running less/eq/greater flags are registered; a done pulse marks the word boundary.
- Successor to the single-bit serial comparators. Used by serial datapaths and the serial ALU lab blocks.

Parameters:
- DIGIT_W, 1, bits consumed per operand per digit, must be >= 1
- WORD_DIGITS, 16, digits per word, must be >= 1
- CNT_W, (WORD_DIGITS > 1 ? $clog2(WORD_DIGITS) : 1), digit counter width, derived and not overridden

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous abort of current word
- valid  input  1  a/b carry a digit this cycle
- msb_first  input  1  1 = most significant digit first; sampled on first digit of word
- is_signed  input  1  1 = two's-complement compare; sampled on first digit of word
- a  input  DIGIT_W  operand A digit
- b  input  DIGIT_W  operand B digit
- a_less_b  output  1  registered running result
- a_eq_b  output  1  registered running result
- a_greater_b  output  1  registered running result
- done  output  1  one-cycle pulse, final digit of word absorbed
- digit_idx  output  CNT_W  index of next digit expected within word

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, immediate, mid-word included): less=0, eq=1, greater=0, done=0, digit_idx=0, latched mode=0, latched sign=0.
- Exactly one of less/eq/greater is 1 at all times.
- Latency: flags at the posedge sampling digit k reflect digits 0..k of the current word, i.e. 1 cycle.
- First digit (digit_idx==0 && valid):
  - latch msb_first and is_signed for the whole word;
  - the previous result is discarded; the digit is compared against the eq state.
- Digit compare value d: LT / EQ / GT of a vs b.
  - Unsigned, except the sign digit, which compares as signed DIGIT_W-bit values when the latched sign is 1.
  - Sign digit is digit 0 in MSB-first mode and digit WORD_DIGITS-1 in LSB-first mode.
- MSB-first update: if state==EQ then state=d, else hold. First non-equal digit decides.
- LSB-first update: if d!=EQ then state=d, else hold. Last non-equal digit decides.
- valid=0: all state and flags hold; done=0; digit_idx holds. Gaps are allowed anywhere in a word.
- digit_idx increments on each valid digit. It wraps to 0 after WORD_DIGITS-1, and on that same edge done=1 for exactly one cycle.
- After done, flags hold the final word result until the next valid digit.
- Back-to-back words are allowed with no idle cycle. The digit after wrap starts a new word.
- clear=1 without valid: digit_idx=0, flags=eq, done=0.
- clear=1 with valid: the digit is treated as digit 0 of a new word. It latches mode/sign and updates the flags; digit_idx=1, or wraps with done=1 if WORD_DIGITS==1.
- Mode/sign inputs on non-first digits are ignored.
- WORD_DIGITS=1: every valid digit is a complete word; done=1 on each valid edge.
- No X propagation from a/b while valid=0.

Test Plan:
1. DIGIT_W=4, WORD_DIGITS=4, unsigned MSB-first, a digits 4,1,2,6 vs b digits 4,6,4,6 -> flags eq, less, less, less; done=1 with digit 4 only; final less.
2. Same operands (a=0x4126, b=0x4646), LSB-first, digits 6,2,1,4 vs 6,4,6,4 -> eq, less, less, less; done on 4th; digit_idx sequence 1,2,3,0.
3. Signed override:
   - MSB-first, a=0x8000, b=0x0001, is_signed=1 -> less from first digit, final less; with is_signed=0 -> greater.
   - LSB-first, a=0x0001, b=0x8000, is_signed=1 -> greater,greater,greater,greater; is_signed=0 -> greater,greater,greater,less.
4. Equal words 0x4726 vs 0x4726 in both modes -> eq every cycle. Then back-to-back word a=0x0000, b=0x0001 LSB-first -> less after its first digit, i.e. no carry-over of the previous result.
5. Gaps, clear and reset:
   - valid dropped for 3 cycles mid-word -> flags/digit_idx hold, done=0.
   - clear with valid at digit_idx=2 -> digit_idx=1, flags from that digit only.
   - rst asserted between clock edges mid-word -> immediate less=0, eq=1, greater=0, digit_idx=0.
6. DIGIT_W=1, WORD_DIGITS=16, and DIGIT_W=8, WORD_DIGITS=1 -> random 1000 words checked against a reference model of the full-word compare at done, both modes and signedness.
